serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor. It adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell. It exposes a start/ready/done handshake and reports carry-out and signed overflow. It is the sequential, width-generic successor to the lab's combinational adder cells, and it is used wherever area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/full_adder_cell.sv | 24 ++
 rtl/serial_adder.sv | 130 +++++++++++++
 tb/tb_serial_adder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

   // Controller states; encodings are fixed so state decodes stay stable.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit-counter width for a given operand width. Must hold 0..w-1;
   // clamped to one bit so a degenerate width still yields a legal vector.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half-adder stages joined by an OR.
module full_adder_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic h1_s, h1_c;
   logic h2_c;

   // First half adder: operand bits.
   assign h1_s = x ^ y;
   assign h1_c = x & y;

   // Second half adder: partial sum plus incoming carry.
   assign s    = h1_s ^ ci;
   assign h2_c = h1_s & ci;

   // At most one half adder can generate a carry, so OR merges them.
   assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH+2
// cycles per operation with a start/ready/done handshake.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  opa_q, opa_d;
   logic [WIDTH-1:0]  opb_q, opb_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              carry_q, carry_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;

   logic              fa_s, fa_co;
   logic              last_bit;

   // The single arithmetic cell; it always looks at the operand LSBs.
   full_adder_cell u_fa (
      .x  (opa_q[0]),
      .y  (opb_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   assign last_bit = (cnt_q == LAST);

   // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: load on acceptance, shift one bit per RUN cycle.
   always_comb begin
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               // Subtract is a + ~b + 1: invert B and seed the carry with 1.
               opa_d   = a;
               opb_d   = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
               res_d   = '0;
            end
         end
         RUN: begin
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               // On the MSB cycle carry_q is the carry into the MSB, so the
               // overflow test needs no separate capture flop.
               sum_d  = {fa_s, res_q[WIDTH-1:1]};
               cout_d = fa_co;
               ovf_d  = carry_q ^ fa_co;
            end
         end
         default: ;
      endcase
   end

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Handshake flags decode straight from the state register.
   assign ready = (state_q == IDLE);
   assign done  = (state_q == DONE);
   assign sum   = sum_q;
   assign cout  = cout_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH 8, plus 4- and 16-bit sweeps.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        start8 = 1'b0, sub8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0, sum8;
   logic        rdy8, done8, cout8, ovf8;

   logic        start4 = 1'b0, sub4 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0, sum4;
   logic        rdy4, done4, cout4, ovf4;

   logic        start16 = 1'b0, sub16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0, sum16;
   logic        rdy16, done16, cout16, ovf16;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .ready(rdy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
      .ready(rdy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

   serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
      .ready(rdy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation with cycle-exact done timing and sum stability.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] es, input logic ec, input logic eo,
                      input string tag);
      logic [7:0] prev;
      @(negedge clk);
      a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
      prev = sum8;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      check({tag, "_ready_run"}, 32'(rdy8), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i < 8) begin
            check({tag, "_done_early"}, 32'(done8), 32'd0);
            check({tag, "_sum_hold"}, 32'(sum8), 32'(prev));
         end
      end
      check({tag, "_done"}, 32'(done8), 32'd1);
      check({tag, "_sum"}, 32'(sum8), 32'(es));
      check({tag, "_cout"}, 32'(cout8), 32'(ec));
      check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
      @(negedge clk);
      check({tag, "_done_fall"}, 32'(done8), 32'd0);
      check({tag, "_ready_back"}, 32'(rdy8), 32'd1);
      check({tag, "_sum_keep"}, 32'(sum8), 32'(es));
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s);
      logic [3:0] ob, es;
      logic [4:0] full;
      logic       eo;
      int         lat;
      ob   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, ob} + {4'b0, s};
      es   = full[3:0];
      eo   = (a[3] == ob[3]) && (es[3] != a[3]);
      @(negedge clk);
      a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      lat = 0;
      while (!done4 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("w4_latency", 32'(lat), 32'd4);
      check("w4_sum", 32'(sum4), 32'(es));
      check("w4_cout", 32'(cout4), 32'(full[4]));
      check("w4_ovf", 32'(ovf4), 32'(eo));
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s);
      logic [15:0] ob, es;
      logic [16:0] full;
      logic        eo;
      int          lat;
      ob   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, ob} + {16'b0, s};
      es   = full[15:0];
      eo   = (a[15] == ob[15]) && (es[15] != a[15]);
      @(negedge clk);
      a16 = a; b16 = b; sub16 = s; start16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0;
      lat = 0;
      while (!done16 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("w16_latency", 32'(lat), 32'd16);
      check("w16_sum", 32'(sum16), 32'(es));
      check("w16_cout", 32'(cout16), 32'(full[16]));
      check("w16_ovf", 32'(ovf16), 32'(eo));
   endtask

   initial begin
      int nd;
      logic [7:0] prev;

      // Reset values.
      #1;
      check("rst_ready", 32'(rdy8), 32'd1);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_sum", 32'(sum8), 32'd0);
      check("rst_cout", 32'(cout8), 32'd0);
      check("rst_ovf", 32'(ovf8), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed arithmetic.
      op8(8'd100, 8'd27,  1'b0, 8'd127,  1'b0, 1'b0, "add_127");
      op8(8'd100, 8'd50,  1'b0, 8'h96,   1'b0, 1'b1, "add_ovf");
      op8(8'hFF,  8'h01,  1'b0, 8'h00,   1'b1, 1'b0, "add_carry");
      op8(8'd5,   8'd7,   1'b1, 8'hFE,   1'b0, 1'b0, "sub_borrow");
      op8(8'h80,  8'h01,  1'b1, 8'h7F,   1'b1, 1'b1, "sub_ovf");

      // Handshake: start held high, operands changed right after acceptance.
      @(negedge clk);
      a8 = 8'd3; b8 = 8'd4; sub8 = 1'b0; start8 = 1'b1;
      prev = sum8;
      @(posedge clk);
      @(negedge clk);
      a8 = 8'hAA; b8 = 8'h11; sub8 = 1'b1;
      nd = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (done8) nd++;
         if (i < 8) check("hs_sum_hold", 32'(sum8), 32'(prev));
      end
      check("hs_first_sum", 32'(sum8), 32'd7);
      check("hs_first_cout", 32'(cout8), 32'd0);
      @(negedge clk);
      check("hs_done_fall", 32'(done8), 32'd0);
      check("hs_ready", 32'(rdy8), 32'd1);
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (done8) nd++;
      end
      check("hs_done_count", 32'(nd), 32'd2);
      check("hs_second_sum", 32'(sum8), 32'h99);
      check("hs_second_cout", 32'(cout8), 32'd1);
      check("hs_second_ovf", 32'(ovf8), 32'd0);
      @(negedge clk);

      // Reset during bit 3 of RUN.
      @(negedge clk);
      a8 = 8'h33; b8 = 8'h44; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 32'(rdy8), 32'd1);
      check("mid_rst_done", 32'(done8), 32'd0);
      check("mid_rst_sum", 32'(sum8), 32'd0);
      check("mid_rst_cout", 32'(cout8), 32'd0);
      check("mid_rst_ovf", 32'(ovf8), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) nd++;
      end
      check("mid_rst_no_done", 32'(nd), 32'd0);
      op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "post_rst");

      // Width sweep with a few corner cases plus random vectors.
      op4(4'h7, 4'h1, 1'b0);
      op4(4'h8, 4'h1, 1'b1);
      for (int i = 0; i < 6; i++)
         op4(4'($urandom), 4'($urandom), 1'($urandom));
      op16(16'hFFFF, 16'h0001, 1'b0);
      op16(16'h7FFF, 16'h0001, 1'b0);
      for (int i = 0; i < 6; i++)
         op16(16'($urandom), 16'($urandom), 1'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
